// File: rtl/arb2x1_32bits_if.sv
`default_nettype none
// ============================================================================
// Module   : arb2x1_32bits_if
// Brief    : Bus bundle for the 2:1 32-bit arbiter: two producer channels
//            (A, B) and one registered output channel toward the sink.
//            slave  = arbiter side, master = producers + sink side.
// Revision : 1.0  initial release
// ============================================================================
interface arb2x1_32bits_if;
  logic        a_valid;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [31:0] b_data;
  logic        b_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_src;
  logic        out_ready;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src
  );
endinterface
`default_nettype wire

// File: rtl/arb2x1_32bits.sv
`default_nettype none
// ============================================================================
// Module   : arb2x1_32bits
// Brief    : 2:1 arbiter for 32-bit words with a single registered output
//            stage. Ties are resolved round-robin; with ARB2_BURST_EN defined
//            a source may keep the grant on ties for up to MAX_BURST words.
// Macro    : ARB2_BURST_EN (optional burst-mode tie resolution)
// Revision : 1.0  initial release
// ============================================================================
module arb2x1_32bits #(
  parameter int MAX_BURST = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  arb2x1_32bits_if.slave      bus
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  // Out-of-range burst limits would silently break the 4-bit counter compare.
  if ((MAX_BURST < 1) || (MAX_BURST > 15)) begin : g_bad_max_burst
    $error("arb2x1_32bits: MAX_BURST must be in 1..15");
  end

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_out_data;
  logic        r_out_src;
  logic        r_last_src;   // 0 = A, 1 = B; reset to B so A wins the first tie
  logic        w_load;
  logic        w_tie_keep;   // on a tie, keep last_src instead of alternating
  logic        w_tie_winner;
  logic        w_grant_b;
  logic        w_accept;

`ifdef ARB2_BURST_EN
  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);
  logic [3:0] r_burst_cnt;

  // A zero count means no burst is in progress, so the tie alternates as usual.
  always_comb begin
    w_tie_keep = (r_burst_cnt != 4'd0) && (r_burst_cnt < c_max_burst);
  end
`else
  // Strict per-transfer alternation on ties.
  always_comb begin
    w_tie_keep = 1'b0;
  end
`endif

  // Grant selection from the current valids and round-robin history only.
  always_comb begin
    w_tie_winner = w_tie_keep ? r_last_src : ~r_last_src;
    w_grant_b    = bus.b_valid && (!bus.a_valid || w_tie_winner);
  end

  // State register for the output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs; ready is gated off while in reset.
  always_comb begin
    w_next_state  = r_state;
    w_load        = 1'b0;
    bus.a_ready   = 1'b0;
    bus.b_ready   = 1'b0;
    bus.out_valid = 1'b0;
    w_accept      = 1'b0;

    case (r_state)
      S_EMPTY: begin
        w_load = 1'b1;
      end
      S_FULL: begin
        bus.out_valid = 1'b1;
        w_load        = bus.out_ready;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase

    if (rst_n) begin
      bus.a_ready = w_load && bus.a_valid && !w_grant_b;
      bus.b_ready = w_load && w_grant_b;
    end
    w_accept = (bus.a_ready && bus.a_valid) || (bus.b_ready && bus.b_valid);

    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_next_state = S_FULL;
        end
      end
      S_FULL: begin
        if (bus.out_ready && !w_accept) begin
          w_next_state = S_EMPTY;
        end
      end
      default: begin
        w_next_state = S_EMPTY;
      end
    endcase
  end

  // Output word register and round-robin history; captured on every accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data <= 32'h0;
      r_out_src  <= 1'b0;
      r_last_src <= 1'b1;
    end else if (w_accept) begin
      r_out_data <= w_grant_b ? bus.b_data : bus.a_data;
      r_out_src  <= w_grant_b;
      r_last_src <= w_grant_b;
    end
  end

`ifdef ARB2_BURST_EN
  // Consecutive-grant counter; saturates so a lone requester is never blocked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_burst_cnt <= 4'd0;
    end else if (w_accept) begin
      if ((r_burst_cnt != 4'd0) && (w_grant_b == r_last_src)) begin
        if (r_burst_cnt < c_max_burst) begin
          r_burst_cnt <= r_burst_cnt + 4'd1;
        end
      end else begin
        r_burst_cnt <= 4'd1;
      end
    end
  end
`endif

  // Registered output channel.
  always_comb begin
    bus.out_data = r_out_data;
    bus.out_src  = r_out_src;
  end

endmodule
`default_nettype wire
